cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/superscalar_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/cdb_arbiter.sv | 103 ++++++++++
 tb/tb_cdb_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/superscalar_pkg.sv
// Shared machine-wide constants for the superscalar core: result bus geometry
// and the fixed requester slots feeding the common data bus.
package superscalar_pkg;

    localparam int NUM_REQ  = 6;
    localparam int TAG_LEN  = 4;
    localparam int DATA_WID = 8;
    localparam int RESULT_W = TAG_LEN + DATA_WID;
    localparam int SRC_W    = 3;

    // Requester slot assignment on the CDB
    localparam int REQ_ADD0   = 0;
    localparam int REQ_ADD1   = 1;
    localparam int REQ_MUL0   = 2;
    localparam int REQ_MUL1   = 3;
    localparam int REQ_FETCH0 = 4;
    localparam int REQ_FETCH1 = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: one-hot grant to the first active request at or
// after ptr_i, wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter int N     = 6,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among result producers, one
// registered broadcast per accepted result, sticky flag for zero tags.
module cdb_arbiter #(
    parameter int NUM_REQ  = superscalar_pkg::NUM_REQ,
    parameter int TAG_LEN  = superscalar_pkg::TAG_LEN,
    parameter int DATA_WID = superscalar_pkg::DATA_WID
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*(TAG_LEN+DATA_WID)-1:0] req_result,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic                                 cdb_stall,
    output logic                                 cdb_valid,
    output logic [TAG_LEN+DATA_WID-1:0]          cdb_result,
    output logic [superscalar_pkg::SRC_W-1:0]    cdb_src,
    output logic                                 tag_err
);

    localparam int RW    = TAG_LEN + DATA_WID;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SRC_W = superscalar_pkg::SRC_W;

    // Handshake: requester i holds req_valid[i] and its result slot stable until
    // req_ready[i]; a transfer happens in any cycle where both are high.
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [RW-1:0]    cdb_result_q, cdb_result_d;
    logic [SRC_W-1:0] cdb_src_q, cdb_src_d;
    logic             tag_err_q, tag_err_d;

    logic [NUM_REQ-1:0] raw_gnt;
    logic [PTR_W-1:0]   g_idx;
    logic [RW-1:0]      sel_result;
    logic               xfer;
    logic               tag_zero;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (raw_gnt)
    );

    assign req_ready = (rst_n && !cdb_stall) ? raw_gnt : '0;

    always_comb begin
        g_idx      = '0;
        sel_result = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                g_idx      = PTR_W'(i);
                sel_result = req_result[i*RW +: RW];
            end
        end
    end

    assign xfer     = |(req_valid & req_ready);
    assign tag_zero = (sel_result[RW-1 -: TAG_LEN] == '0);

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        cdb_valid_d  = 1'b0;
        cdb_result_d = cdb_result_q;
        cdb_src_d    = cdb_src_q;
        tag_err_d    = tag_err_q;
        if (xfer) begin
            rr_ptr_d = (g_idx == PTR_W'(NUM_REQ-1)) ? '0 : g_idx + PTR_W'(1);
            // Zero-tag results are consumed but never broadcast
            if (tag_zero) begin
                tag_err_d = 1'b1;
            end else begin
                cdb_valid_d  = 1'b1;
                cdb_result_d = sel_result;
                cdb_src_d    = SRC_W'(g_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_result_q <= '0;
            cdb_src_q    <= '0;
            tag_err_q    <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_result_q <= cdb_result_d;
            cdb_src_q    <= cdb_src_d;
            tag_err_q    <= tag_err_d;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_result = cdb_result_q;
    assign cdb_src    = cdb_src_q;
    assign tag_err    = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grant order, broadcast timing, stall,
// zero-tag handling and asynchronous reset.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [5:0]  req_valid;
    logic [71:0] req_result;
    logic [5:0]  req_ready;
    logic        cdb_stall;
    logic        cdb_valid;
    logic [11:0] cdb_result;
    logic [2:0]  cdb_src;
    logic        tag_err;

    int n_cmp = 0;
    int n_err = 0;

    cdb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_result (req_result),
        .req_ready  (req_ready),
        .cdb_stall  (cdb_stall),
        .cdb_valid  (cdb_valid),
        .cdb_result (cdb_result),
        .cdb_src    (cdb_src),
        .tag_err    (tag_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [3:0] t, input logic [7:0] d);
        req_result[i*12 +: 12] = {t, d};
    endtask

    initial begin
        rst_n      = 1'b0;
        cdb_stall  = 1'b0;
        req_valid  = 6'b111111;
        req_result = '0;

        // Reset state, before any clock edge
        #2;
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_eq("rst_valid", 32'(cdb_valid), 32'h0);
        check_eq("rst_result", 32'(cdb_result), 32'h0);
        check_eq("rst_src", 32'(cdb_src), 32'h0);
        check_eq("rst_tag_err", 32'(tag_err), 32'h0);

        // Single transfer from requester 0
        tick();
        rst_n     = 1'b1;
        req_valid = 6'b000001;
        set_slot(0, 4'h9, 8'h2A);
        #1;
        check_eq("single_ready", 32'(req_ready), 32'h01);
        tick();
        check_eq("single_valid", 32'(cdb_valid), 32'h1);
        check_eq("single_result", 32'(cdb_result), 32'h92A);
        check_eq("single_src", 32'(cdb_src), 32'h0);
        req_valid = 6'b000000;
        #1;
        check_eq("idle_ready", 32'(req_ready), 32'h0);
        tick();
        check_eq("idle_valid", 32'(cdb_valid), 32'h0);
        check_eq("idle_hold_result", 32'(cdb_result), 32'h92A);
        check_eq("idle_hold_src", 32'(cdb_src), 32'h0);

        // All six requesting for 12 cycles after a fresh reset
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) set_slot(i, 4'(i + 1), 8'(8'h10 + i));
        req_valid = 6'b111111;
        for (int k = 0; k < 12; k++) begin
            #1;
            check_eq("rr_ready", 32'(req_ready), 32'(1) << (k % 6));
            tick();
            check_eq("rr_valid", 32'(cdb_valid), 32'h1);
            check_eq("rr_src", 32'(cdb_src), 32'(k % 6));
            check_eq("rr_result", 32'(cdb_result), 32'(((k % 6) + 1) * 256 + 16 + (k % 6)));
        end

        // Move pointer to 3 by granting requester 2
        req_valid = 6'b000100;
        #1;
        check_eq("ptr3_ready", 32'(req_ready), 32'h04);
        tick();
        req_valid = 6'b010100;
        #1;
        check_eq("skip_ready4", 32'(req_ready), 32'h10);
        tick();
        check_eq("skip_src4", 32'(cdb_src), 32'h4);
        check_eq("skip_result4", 32'(cdb_result), 32'h514);
        req_valid = 6'b000100;
        #1;
        check_eq("skip_ready2", 32'(req_ready), 32'h04);
        tick();
        check_eq("skip_src2", 32'(cdb_src), 32'h2);
        req_valid = 6'b111111;
        #1;
        check_eq("ptr_is_3", 32'(req_ready), 32'h08);
        req_valid = 6'b000000;
        #1;
        tick();
        check_eq("ptr3_idle_valid", 32'(cdb_valid), 32'h0);

        // Stall for three cycles with requester 1 pending
        cdb_stall = 1'b1;
        req_valid = 6'b000010;
        repeat (3) begin
            #1;
            check_eq("stall_ready", 32'(req_ready), 32'h0);
            tick();
            check_eq("stall_valid", 32'(cdb_valid), 32'h0);
        end
        cdb_stall = 1'b0;
        #1;
        check_eq("unstall_ready", 32'(req_ready), 32'h02);
        tick();
        check_eq("unstall_valid", 32'(cdb_valid), 32'h1);
        check_eq("unstall_src", 32'(cdb_src), 32'h1);

        // Zero tag on requester 5
        req_valid = 6'b100000;
        set_slot(5, 4'h0, 8'h55);
        #1;
        check_eq("tag0_ready", 32'(req_ready), 32'h20);
        tick();
        check_eq("tag0_valid", 32'(cdb_valid), 32'h0);
        check_eq("tag0_err", 32'(tag_err), 32'h1);
        check_eq("tag0_hold_src", 32'(cdb_src), 32'h1);
        check_eq("tag0_hold_result", 32'(cdb_result), 32'h211);
        req_valid = 6'b000001;
        set_slot(0, 4'h9, 8'h2A);
        #1;
        check_eq("tag0_wrap_ready", 32'(req_ready), 32'h01);
        tick();
        check_eq("after_tag0_valid", 32'(cdb_valid), 32'h1);
        req_valid = 6'b000000;
        repeat (3) tick();
        check_eq("tag_err_sticky", 32'(tag_err), 32'h1);

        // Reset during requester 3 transfer (pointer is 1)
        req_valid = 6'b001001;
        #1;
        check_eq("inflight_ready", 32'(req_ready), 32'h08);
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready", 32'(req_ready), 32'h0);
        check_eq("arst_tag_err", 32'(tag_err), 32'h0);
        check_eq("arst_valid", 32'(cdb_valid), 32'h0);
        check_eq("arst_src", 32'(cdb_src), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_valid", 32'(cdb_valid), 32'h0);
        check_eq("post_rst_ready", 32'(req_ready), 32'h01);
        tick();
        check_eq("post_rst_cdb_valid", 32'(cdb_valid), 32'h1);
        check_eq("post_rst_src", 32'(cdb_src), 32'h0);
        check_eq("post_rst_result", 32'(cdb_result), 32'h92A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
